// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, branch redirect with
// a squashed flush window, stall hold and a terminal halt state.
module pc_sequencer #(
    parameter int                    AddrBits    = 32,
    parameter logic [AddrBits-1:0]   ResetVector = '0,
    parameter int                    FlushCycles = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                Stall,
    input  logic                BranchTaken,
    input  logic [AddrBits-1:0] BranchDest,
    input  logic                Halt,
    output logic [AddrBits-1:0] PC,
    output logic                FetchValid,
    output logic                Flushing,
    output logic                Halted,
    output logic [7:0]          RedirectCount
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Fetch addresses are always word aligned.
    localparam logic [AddrBits-1:0] AlignMask = ~AddrBits'(3);
    localparam logic [AddrBits-1:0] ResetPc   = ResetVector & AlignMask;
    localparam logic [3:0]          FlushLoad = 4'(FlushCycles);

    state_e              state_q, state_d;
    logic [AddrBits-1:0] pc_q, pc_d;
    logic [3:0]          flush_cnt_q, flush_cnt_d;
    logic [7:0]          redir_cnt_q, redir_cnt_d;
    logic                advance;

    assign advance = ClockEnable & Tick;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_cnt_d = flush_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (advance) begin
            unique case (state_q)
                RUN, FLUSH: begin
                    if (Halt) begin
                        state_d = HALTED;
                    end else if (BranchTaken) begin
                        pc_d        = BranchDest & AlignMask;
                        flush_cnt_d = FlushLoad;
                        state_d     = FLUSH;
                        if (redir_cnt_q != 8'hFF) begin
                            redir_cnt_d = redir_cnt_q + 8'd1;
                        end
                    end else if (!Stall) begin
                        pc_d = pc_q + AddrBits'(4);
                        if (state_q == FLUSH) begin
                            flush_cnt_d = flush_cnt_q - 4'd1;
                            if (flush_cnt_q <= 4'd1) begin
                                flush_cnt_d = 4'd0;
                                state_d     = RUN;
                            end
                        end
                    end
                end
                default: begin
                    state_d = HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= RUN;
            pc_q        <= ResetPc;
            flush_cnt_q <= 4'd0;
            redir_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign PC            = pc_q;
    assign FetchValid    = (state_q == RUN);
    assign Flushing      = (state_q == FLUSH);
    assign Halted        = (state_q == HALTED);
    assign RedirectCount = redir_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, redirect/flush,
// stall, wrap, halt, async reset and redirect-count saturation.
module tb_pc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ClockEnable;
    logic        Tick;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchDest;
    logic        Halt;
    logic [31:0] PC;
    logic        FetchValid;
    logic        Flushing;
    logic        Halted;
    logic [7:0]  RedirectCount;

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(
        .AddrBits    (32),
        .ResetVector (32'h0),
        .FlushCycles (2)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .ClockEnable   (ClockEnable),
        .Tick          (Tick),
        .Stall         (Stall),
        .BranchTaken   (BranchTaken),
        .BranchDest    (BranchDest),
        .Halt          (Halt),
        .PC            (PC),
        .FetchValid    (FetchValid),
        .Flushing      (Flushing),
        .Halted        (Halted),
        .RedirectCount (RedirectCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic state(input string tag, input logic [31:0] pc,
                         input logic fv, input logic fl,
                         input logic h, input logic [7:0] rc);
        check({tag, ".pc"}, PC, pc);
        check({tag, ".fv"}, 32'(FetchValid), 32'(fv));
        check({tag, ".fl"}, 32'(Flushing), 32'(fl));
        check({tag, ".h"}, 32'(Halted), 32'(h));
        check({tag, ".rc"}, 32'(RedirectCount), 32'(rc));
    endtask

    task automatic step(input logic st, input logic br,
                        input logic [31:0] d, input logic h);
        Stall       = st;
        BranchTaken = br;
        BranchDest  = d;
        Halt        = h;
        @(posedge Clock);
        #1;
        Stall       = 1'b0;
        BranchTaken = 1'b0;
        Halt        = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        ClockEnable = 1'b1;
        Tick        = 1'b1;
        Stall       = 1'b0;
        BranchTaken = 1'b0;
        BranchDest  = 32'h0;
        Halt        = 1'b0;
        #3;
        state("reset", 32'h0, 1, 0, 0, 8'd0);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        state("post_rst", 32'h0, 1, 0, 0, 8'd0);

        step(0, 0, 0, 0);
        state("seq1", 32'h4, 1, 0, 0, 8'd0);
        step(0, 0, 0, 0);
        state("seq2", 32'h8, 1, 0, 0, 8'd0);

        step(0, 1, 32'h1003, 0);
        state("br1", 32'h1000, 0, 1, 0, 8'd1);
        step(0, 0, 0, 0);
        state("fl1", 32'h1004, 0, 1, 0, 8'd1);
        step(0, 0, 0, 0);
        state("fl_end", 32'h1008, 1, 0, 0, 8'd1);

        ClockEnable = 1'b0;
        step(0, 1, 32'h4444, 1);
        state("ce_off", 32'h1008, 1, 0, 0, 8'd1);
        ClockEnable = 1'b1;
        Tick        = 1'b0;
        step(0, 0, 0, 0);
        state("tick_off", 32'h1008, 1, 0, 0, 8'd1);
        Tick = 1'b1;
        step(1, 0, 0, 0);
        state("run_stall", 32'h1008, 1, 0, 0, 8'd1);
        step(0, 0, 0, 0);
        state("seq3", 32'h100C, 1, 0, 0, 8'd1);

        step(0, 1, 32'h500, 0);
        state("br2", 32'h500, 0, 1, 0, 8'd2);
        step(0, 0, 0, 0);
        state("br2_adv", 32'h504, 0, 1, 0, 8'd2);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            state("fl_stall", 32'h504, 0, 1, 0, 8'd2);
        end
        step(1, 1, 32'h200, 0);
        state("rebr", 32'h200, 0, 1, 0, 8'd3);
        step(0, 0, 0, 0);
        state("rebr_a1", 32'h204, 0, 1, 0, 8'd3);
        step(0, 0, 0, 0);
        state("rebr_a2", 32'h208, 1, 0, 0, 8'd3);

        step(0, 1, 32'hFFFF_FFF7, 0);
        state("wr_br", 32'hFFFF_FFF4, 0, 1, 0, 8'd4);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        state("wr_top", 32'hFFFF_FFFC, 1, 0, 0, 8'd4);
        step(0, 0, 0, 0);
        state("wrap", 32'h0, 1, 0, 0, 8'd4);

        step(0, 1, 32'h300, 0);
        state("br3", 32'h300, 0, 1, 0, 8'd5);
        #2;
        Reset = 1'b1;
        #1;
        state("async_rst", 32'h0, 1, 0, 0, 8'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        step(0, 0, 0, 0);
        state("rst_resume", 32'h4, 1, 0, 0, 8'd0);

        step(0, 1, 32'h7000, 1);
        state("halt", 32'h4, 0, 0, 1, 8'd0);
        step(0, 1, 32'h8000, 0);
        state("halt_br", 32'h4, 0, 0, 1, 8'd0);
        step(0, 0, 0, 0);
        state("halt_seq", 32'h4, 0, 0, 1, 8'd0);
        #2;
        Reset = 1'b1;
        #1;
        state("halt_rst", 32'h0, 1, 0, 0, 8'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        for (int i = 1; i <= 254; i++) begin
            step(0, 1, 32'(i * 16), 0);
        end
        check("rc254", 32'(RedirectCount), 32'd254);
        step(0, 1, 32'h10, 0);
        check("rc255", 32'(RedirectCount), 32'd255);
        for (int i = 0; i < 45; i++) begin
            step(0, 1, 32'(i * 32), 0);
        end
        state("rc_sat", 32'(44 * 32), 0, 1, 0, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
